// File: rtl/jacobi_pkg.sv
// Shared fixed-point constants, types and state encoding for the Jacobi solver
// and its diagonal-reciprocal feeder.
package jacobi_pkg;

    localparam int DEF_PRECISION = 16;
    localparam int DEF_POINT     = 8;

    function automatic int calc_n(input int precision, input int point);
        return precision + point;
    endfunction

    // Quotient bits needed for 2^(2*POINT) / |d| when |d| >= 1.
    function automatic int calc_qbits(input int point);
        return 2 * point + 1;
    endfunction

    localparam int DEF_N = calc_n(DEF_PRECISION, DEF_POINT);

    typedef logic signed [DEF_N-1:0] fx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        FINISH,
        DONE
    } recip_state_t;

endpackage

// File: rtl/recip_div_core.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first,
// DW cycles per pass after the load edge.
module recip_div_core #(
    parameter int DW = 17,
    parameter int VW = 25
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quot
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_divisor;
    logic [VW-1:0] r_rem;
    logic [DW-1:0] r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic [VW:0]   w_shift;
    logic [VW:0]   w_sub;
    logic          w_ge;

    // Handshake: i_load is taken only while o_busy is low; o_done is high in the
    // cycle whose closing edge retires the last quotient bit, after which o_quot holds.
    assign w_shift = {r_rem, r_dvd[DW-1]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_sub   = w_shift - {1'b0, r_divisor};

    assign o_busy  = r_busy;
    assign o_done  = r_busy && (r_cnt == '0);
    assign o_quot  = r_quot;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dvd     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else if (i_load && !r_busy) begin
            r_dvd     <= i_dividend;
            r_divisor <= i_divisor;
            r_rem     <= '0;
            r_quot    <= '0;
            r_cnt     <= CW'(DW - 1);
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_dvd  <= {r_dvd[DW-2:0], 1'b0};
            r_rem  <= w_ge ? w_sub[VW-1:0] : w_shift[VW-1:0];
            r_quot <= {r_quot[DW-2:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/diag_reciprocal.sv
// Computes recip[i] = 1/diag[i] in signed Q(PRECISION.POINT) for every diagonal
// element, serially through one shared restoring divider.
module diag_reciprocal
    import jacobi_pkg::*;
#(
    parameter int   SIZE      = 3,
    parameter int   PRECISION = DEF_PRECISION,
    parameter int   POINT     = DEF_POINT,
    localparam int  N         = calc_n(PRECISION, POINT)
) (
    input  logic                clk,
    input  logic                I_RST,
    input  logic                start,
    input  logic signed [N-1:0] diag [SIZE],
    output logic signed [N-1:0] recip [SIZE],
    output logic                ready,
    output logic                busy,
    output logic [SIZE-1:0]     div_zero,
    output recip_state_t        o_dbg_state
);

    localparam int QBITS = calc_qbits(POINT);
    localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [QBITS-1:0]  DIVIDEND = {1'b1, {(2*POINT){1'b0}}};
    localparam logic signed [N-1:0] MAXV   = {1'b0, {(N-1){1'b1}}};

    recip_state_t        r_state;
    recip_state_t        w_next;
    logic signed [N-1:0] r_diag  [SIZE];
    logic signed [N-1:0] r_recip [SIZE];
    logic [IW-1:0]       r_idx;
    logic                r_ready;
    logic                r_busy;
    logic [SIZE-1:0]     r_div_zero;
    logic                r_sign;
    logic                r_zero;

    logic signed [N-1:0] w_d;
    logic [N:0]          w_d_ext;
    logic [N:0]          w_mag;
    logic                w_div_load;
    logic                w_div_busy;
    logic                w_div_done;
    logic [QBITS-1:0]    w_quot;
    logic [N:0]          w_q_ext;
    logic signed [N-1:0] w_result;
    logic                w_last;

    // start is a one-cycle request honoured only in IDLE/DONE; ready qualifies recip.
    assign w_d        = r_diag[r_idx];
    assign w_d_ext    = {w_d[N-1], w_d};
    assign w_mag      = w_d[N-1] ? -w_d_ext : w_d_ext;
    assign w_div_load = (r_state == LOAD) && !w_div_busy;
    assign w_q_ext    = (N+1)'(w_quot);
    assign w_last     = (r_idx == IW'(SIZE - 1));

    recip_div_core #(
        .DW (QBITS),
        .VW (N + 1)
    ) u_div (
        .i_clk      (clk),
        .i_rst      (I_RST),
        .i_load     (w_div_load),
        .i_dividend (DIVIDEND),
        .i_divisor  (w_mag),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    always_comb begin
        w_result = MAXV;
        if (!r_zero) begin
            if (w_q_ext > {1'b0, MAXV}) begin
                w_result = r_sign ? -MAXV : MAXV;
            end else begin
                w_result = r_sign ? -w_q_ext[N-1:0] : w_q_ext[N-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = LOAD;
            LOAD:       w_next = DIVIDE;
            DIVIDE:     if (w_div_done) w_next = FINISH;
            FINISH:     w_next = w_last ? DONE : LOAD;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            r_idx      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= '0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                r_diag[i]  <= '0;
                r_recip[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < SIZE; i++) begin
                            r_diag[i] <= diag[i];
                        end
                        r_idx      <= '0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_div_zero <= '0;
                    end
                end
                LOAD: begin
                    r_sign <= w_d[N-1];
                    r_zero <= (w_d == '0);
                end
                FINISH: begin
                    r_recip[r_idx]    <= w_result;
                    r_div_zero[r_idx] <= r_zero;
                    if (w_last) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign recip       = r_recip;
    assign ready       = r_ready;
    assign busy        = r_busy;
    assign div_zero    = r_div_zero;
    assign o_dbg_state = r_state;

endmodule

// File: doc/diag_reciprocal.md
Name: diag_reciprocal

Overview:
Upstream feeder for the Jacobi solver. It computes the fixed-point reciprocal 1/A[i][i] of every diagonal element using one shared sequential restoring divider. It presents the results as a register array plus a completion level, which drive the solver's D_reciprocal inputs and reciprocal-complete gate. Elements are processed serially, one divider pass each, so no parallel qdiv instances are needed.

Parameters:
SIZE, 3, number of diagonal elements (matrix order)
PRECISION, 16, integer bits of the fixed-point word
POINT, 8, fractional bits; word width N = PRECISION+POINT, signed two's complement

Ports:
clk  input  1  system clock; all state updates on rising edge
I_RST  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to (re)compute all reciprocals; sampled on clk
diag  input  N x SIZE (signed array)  diagonal elements A[i][i]; latched for all i on the cycle start is accepted
recip  output  N x SIZE (signed array, registered)  recip[i] = 1/diag[i] in the same Q format
ready  output  1  high when every recip[i] is valid for the latched diag set
busy  output  1  high while a computation is in progress
div_zero  output  SIZE  bit i set when diag[i] was zero on the last run

Behaviour:
- Reset (async, I_RST=1): all recip = 0, ready = 0, busy = 0, div_zero = 0, FSM = IDLE. Asserting reset mid-run aborts the run immediately; no partial result survives.
- Acceptance: start is accepted in IDLE or DONE only; ignored while busy. Acceptance latches diag[0..SIZE-1], clears ready and div_zero, sets busy, sets element index to 0, and moves to LOAD.
- FSM: IDLE -> LOAD -> DIVIDE -> FINISH -> (LOAD for the next index | DONE). DONE -> LOAD on an accepted start.
- LOAD (1 cycle): sign = msb(d); magnitude = |d| (N+1-bit, so the most negative value is handled); dividend = 2^(2*POINT); remainder = 0; bit counter = QBITS-1, where QBITS = 2*POINT+1.
- DIVIDE (QBITS cycles): standard restoring division, MSB first, one quotient bit per cycle.
- FINISH (1 cycle):
  - If d == 0: recip[i] = +max (2^(N-1)-1) and div_zero[i] = 1.
  - Otherwise, if the quotient exceeds 2^(N-1)-1, saturate to +max, or to -max when negative.
  - Otherwise recip[i] = sign ? -q : q. Truncation is toward zero.
  - Then increment the index; if index == SIZE-1, go to DONE, set ready = 1 and clear busy.
- Latency: with the accept edge as edge 0, recip[i] is written at edge (i+1)*(QBITS+2). ready and busy are updated at edge SIZE*(QBITS+2). Defaults give 19 cycles per element and 57 cycles total.
- Output stability:
  - recip entries not yet recomputed keep their previous values during a rerun. Only ready qualifies them.
  - In DONE, outputs hold indefinitely.
  - Changes on diag after acceptance have no effect.
- A start arriving on the same edge that DONE is entered is ignored; busy is still high in that cycle.

Decomposition:
- Package jacobi_pkg holds the shared fixed-point constants and types:
  - default PRECISION and POINT, plus the derived N and QBITS functions;
  - the fx_t signed typedef;
  - the recip_state_t enum (IDLE, LOAD, DIVIDE, FINISH, DONE).
  The solver uses the same package.
- One natural sub-module, recip_div_core: a sequential unsigned restoring divider with load/busy/done handshake and a QBITS-cycle pass. The top holds the FSM, index counter, sign/saturation logic and output array.

Test Plan:
(Defaults SIZE=3, PRECISION=16, POINT=8, N=24.)
- diag = {256, 512, -1024} (1.0, 2.0, -4.0), start pulse -> recip = {256, 128, -64}; ready rises exactly 57 cycles after the accept edge; div_zero = 0.
- diag = {768, -768, 1} -> recip = {85, -85, 65536}; checks truncation toward zero, negative sign, and the smallest positive divisor.
- diag = {0, -8388608, 256} -> recip[0] = 8388607 and div_zero = 3'b001; recip[1] = 0 (-1/32768, which truncates to 0); recip[2] = 256.
- Second start pulse during a run (cycle 20), then diag changed to {512, 512, 512} before the run completes -> the second start is ignored; results match the originally latched diag; busy stays high throughout.
- Assert I_RST at cycle 30 of a run -> all recip, ready, busy and div_zero read 0 immediately (asynchronously); a subsequent start completes normally with correct values.
- Run to DONE with {256, 256, 256}, then start with {512, 512, 512} -> ready drops on the accept edge; recip[0] becomes 128 at edge 19 while recip[1] and recip[2] still read 256; ready rises again at edge 57.
